// File: rtl/serial_sync_ctrl.sv
// serial_sync_ctrl
// Bit-serial byte aligner. Hunts for SYNC_BYTE at any bit offset, confirms
// SYNC_COUNT aligned copies, then delivers every non-SYNC byte on DATA_OUT
// with a one-cycle VALID_OUT strobe. SYNC bytes seen while active are filler.
//
// Optional feature (macro LOSS_OF_SYNC_EN): after MAX_GAP consecutive
// non-SYNC bytes the link drops back to HUNT. Without the macro, ACTIVE is
// only left through RESET.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_HUNT   | sliding bit-level search for SYNC_BYTE in the shift register
// ST_ALIGN  | byte phase fixed; counting consecutive aligned SYNC bytes
// ST_ACTIVE | locked; delivering payload bytes, SYNC bytes are dropped

module serial_sync_ctrl #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4,
    parameter int unsigned MAX_GAP    = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       VALID_OUT,
    output logic       ACTIVE
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] SYNC_TARGET  = 4'(SYNC_COUNT);
    // An all-zero SYNC byte would match the cleared shift register right
    // after reset; only then do we wait for eight real bits before hunting.
    localparam logic       SYNC_IS_ZERO = (SYNC_BYTE == 8'h00);

    state_t     state_q;
    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic [2:0] bit_cnt_q;
    logic [3:0] sync_cnt_q;
    logic [3:0] sync_cnt_d;
    logic [3:0] fill_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       active_q;

    logic       sr_match;
    logic       boundary;
    logic       hunt_hit;
    logic       gap_hit;

    assign sr_d       = {sr_q[6:0], DATA_IN};
    assign sync_cnt_d = sync_cnt_q + 4'd1;
    assign sr_match   = (sr_q == SYNC_BYTE);
    assign boundary   = (bit_cnt_q == 3'd0);
    assign hunt_hit   = sr_match && (!SYNC_IS_ZERO || fill_q[3]);

`ifdef LOSS_OF_SYNC_EN
    localparam logic [7:0] GAP_TARGET = 8'(MAX_GAP);

    logic [7:0] gap_cnt_q;
    logic [7:0] gap_cnt_d;

    assign gap_cnt_d = gap_cnt_q + 8'd1;
    assign gap_hit   = (gap_cnt_d == GAP_TARGET);

    // Run length of payload bytes since the last SYNC byte while active.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            gap_cnt_q <= '0;
        end else if (state_q == ST_ACTIVE && boundary) begin
            if (sr_match || gap_hit) begin
                gap_cnt_q <= '0;
            end else begin
                gap_cnt_q <= gap_cnt_d;
            end
        end
    end
`else
    assign gap_hit = 1'b0;
`endif

    // Alignment FSM with shift register, byte-phase counters and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            fill_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            valid_q <= 1'b0;
            if (!fill_q[3]) begin
                fill_q <= fill_q + 4'd1;
            end
            case (state_q)
                ST_HUNT: begin
                    if (hunt_hit) begin
                        // the matching byte is the first of the run; the
                        // next byte boundary is eight cycles away
                        bit_cnt_q  <= 3'd1;
                        sync_cnt_q <= 4'd1;
                        if (SYNC_TARGET == 4'd1) begin
                            state_q  <= ST_ACTIVE;
                            active_q <= 1'b1;
                        end else begin
                            state_q <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        if (sr_match) begin
                            sync_cnt_q <= sync_cnt_d;
                            if (sync_cnt_d == SYNC_TARGET) begin
                                state_q  <= ST_ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state_q    <= ST_HUNT;
                            sync_cnt_q <= '0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary && !sr_match) begin
                        data_q  <= sr_q;
                        valid_q <= 1'b1;
                        // the byte that exhausts the gap budget is still delivered
                        if (gap_hit) begin
                            state_q    <= ST_HUNT;
                            active_q   <= 1'b0;
                            sync_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_HUNT;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign DATA_OUT  = data_q;
    assign VALID_OUT = valid_q;
    assign ACTIVE    = active_q;

endmodule

// File: tb/tb_serial_sync_ctrl.sv
// Testbench for serial_sync_ctrl: vector table, hand sequences for reset and
// gap handling, and random bit streams checked against a window-scan model.
module tb_serial_sync_ctrl;

    localparam logic [7:0] SYNC_B = 8'hBC;
    localparam int         SYNC_N = 4;
    localparam int         GAP_N  = 16;
    localparam int         MAXB   = 2048;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       DATA_IN = 1'b0;
    logic [7:0] DATA_OUT;
    logic       VALID_OUT;
    logic       ACTIVE;
    logic [7:0] d0_data;
    logic       d0_valid;
    logic       d0_active;

    serial_sync_ctrl #(.SYNC_BYTE(SYNC_B), .SYNC_COUNT(SYNC_N), .MAX_GAP(GAP_N)) dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT), .ACTIVE(ACTIVE)
    );

    // zero sync byte, single-sync lock: exercises the post-reset fill guard
    serial_sync_ctrl #(.SYNC_BYTE(8'h00), .SYNC_COUNT(1), .MAX_GAP(GAP_N)) dut0 (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN),
        .DATA_OUT(d0_data), .VALID_OUT(d0_valid), .ACTIVE(d0_active)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic       stream [MAXB];
    int         slen;
    logic       obs_valid  [MAXB];
    logic       obs_active [MAXB];
    logic [7:0] obs_data   [MAXB];
    logic       obs0_valid [MAXB];
    logic       obs0_active[MAXB];
    logic [7:0] obs0_data  [MAXB];
    logic       exp_valid  [MAXB];
    logic       exp_active [MAXB];
    logic [7:0] exp_data   [MAXB];
    logic [7:0] ev_data    [MAXB];

    typedef struct {
        string      name;
        int         prefix_bits;
        logic [7:0] prefix;
        int         nbytes;
        logic [79:0] bytes;
        int         exp_pulses;
        logic [7:0] exp_last;
        logic       exp_active;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        stream[slen] = b;
        slen = slen + 1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET   = 1'b1;
        DATA_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic sample(input int k);
        obs_valid[k]   = VALID_OUT;
        obs_active[k]  = ACTIVE;
        obs_data[k]    = DATA_OUT;
        obs0_valid[k]  = d0_valid;
        obs0_active[k] = d0_active;
        obs0_data[k]   = d0_data;
    endtask

    // Called at a negedge; index 0 is the state before the first bit is clocked.
    task automatic stream_bits(input int n);
        sample(0);
        for (int k = 0; k < n; k++) begin
            DATA_IN = stream[k];
            @(posedge CLK);
            @(negedge CLK);
            sample(k + 1);
        end
    endtask

    function automatic int count_pulses(input int n);
        int c = 0;
        for (int k = 0; k <= n; k++) if (obs_valid[k] === 1'b1) c++;
        return c;
    endfunction

    // Byte formed by the eight bits clocked before cycle t, first bit as MSB.
    function automatic logic [7:0] win(input int t);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[7-i] = stream[t-8+i];
        return w;
    endfunction

    // Reference: scan the stream for a SYNC window, follow it in steps of 8
    // bits, lock after SYNC_N in a row, then deliver every non-SYNC window.
    task automatic build_model(input int n);
        int  t, u, v, cnt, gap;
        bit  lost;
        logic [7:0] d;
        for (int k = 0; k <= n + 1; k++) begin
            exp_valid[k] = 1'b0; exp_active[k] = 1'b0; ev_data[k] = 8'h00;
        end
        t = 8;
        while (t <= n) begin
            if (win(t) != SYNC_B) begin
                t++;
                continue;
            end
            cnt = 1;
            u   = t;
            while (cnt < SYNC_N && u + 8 <= n && win(u + 8) == SYNC_B) begin
                u += 8;
                cnt++;
            end
            if (cnt < SYNC_N) begin
                t = u + 9;
                continue;
            end
            for (int k = u + 1; k <= n; k++) exp_active[k] = 1'b1;
            lost = 1'b0;
            gap  = 0;
            v    = u + 8;
            while (v <= n && !lost) begin
                if (win(v) != SYNC_B) begin
                    exp_valid[v+1] = 1'b1;
                    ev_data[v+1]   = win(v);
                    gap++;
`ifdef LOSS_OF_SYNC_EN
                    if (gap == GAP_N) lost = 1'b1;
`endif
                end else begin
                    gap = 0;
                end
                v += 8;
            end
            if (!lost) break;
            v -= 8;
            for (int k = v + 1; k <= n; k++) exp_active[k] = 1'b0;
            t = v + 1;
        end
        d = 8'h00;
        for (int k = 0; k <= n; k++) begin
            if (exp_valid[k]) d = ev_data[k];
            exp_data[k] = d;
        end
    endtask

    task automatic compare_model(input string tag, input int n);
        build_model(n);
        for (int k = 0; k <= n; k++) begin
            check({tag, " valid"},  k, 8'(obs_valid[k]),  8'(exp_valid[k]));
            check({tag, " active"}, k, 8'(obs_active[k]), 8'(exp_active[k]));
            check({tag, " data"},   k, obs_data[k],       exp_data[k]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, v1, v2, pulses, drops;

        vecs[0] = '{"lock_11_22",   0, 8'h00, 6, 80'hBCBCBCBC1122_00000000,     2, 8'h22, 1'b1};
        vecs[1] = '{"slip3_A5",     3, 8'h05, 5, 80'hBCBCBCBCA5_0000000000,     1, 8'hA5, 1'b1};
        vecs[2] = '{"break_3C",     0, 8'h00, 8, 80'hBCBC3CBCBCBCBC55_0000,     1, 8'h55, 1'b1};
        vecs[3] = '{"filler_77_88", 0, 8'h00, 7, 80'hBCBCBCBC77BC88_000000,     2, 8'h88, 1'b1};
        vecs[4] = '{"short_sync",   0, 8'h00, 4, 80'hBCBCBC11_000000000000,     0, 8'h00, 1'b0};
        vecs[5] = '{"all_sync",     0, 8'h00, 6, 80'hBCBCBCBCBCBC_00000000,     0, 8'h00, 1'b1};
        vecs[6] = '{"junk_first",   0, 8'h00, 7, 80'h3C5ABCBCBCBCC3_000000,     1, 8'hC3, 1'b1};

        // reset values
        do_reset();
        check("reset data",   0, DATA_OUT,         8'h00);
        check("reset valid",  0, 8'(VALID_OUT),    8'h00);
        check("reset active", 0, 8'(ACTIVE),       8'h00);

        // vector table; two SYNC filler bytes let the last strobe appear
        for (int i = 0; i < 7; i++) begin
            slen = 0;
            for (int b = vecs[i].prefix_bits - 1; b >= 0; b--) push_bit(vecs[i].prefix[b]);
            for (int b = 0; b < vecs[i].nbytes; b++) push_byte(vecs[i].bytes[79 - 8*b -: 8]);
            push_byte(SYNC_B);
            push_byte(SYNC_B);
            do_reset();
            stream_bits(slen);
            check({vecs[i].name, " pulses"}, slen, 8'(count_pulses(slen)), 8'(vecs[i].exp_pulses));
            check({vecs[i].name, " last"},   slen, obs_data[slen],         vecs[i].exp_last);
            check({vecs[i].name, " active"}, slen, 8'(obs_active[slen]),   8'(vecs[i].exp_active));
            compare_model(vecs[i].name, slen);
        end

        // lock timing: 4th SYNC boundary at cycle 32, payload boundaries at 40 and 48
        slen = 0;
        repeat (4) push_byte(SYNC_B);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(SYNC_B);
        do_reset();
        stream_bits(slen);
        first = -1; v1 = -1; v2 = -1;
        for (int k = slen; k >= 0; k--) begin
            if (obs_active[k] === 1'b1) first = k;
        end
        for (int k = 0; k <= slen; k++) begin
            if (obs_valid[k] === 1'b1) begin
                if (v1 < 0) v1 = k;
                else if (v2 < 0) v2 = k;
            end
        end
        check("timing active_rise", first, 8'(first), 8'd33);
        check("timing valid1",      v1,    8'(v1),    8'd41);
        check("timing data1",       41,    obs_data[41], 8'h11);
        check("timing valid2",      v2,    8'(v2),    8'd49);
        check("timing data2",       49,    obs_data[49], 8'h22);

        // zero SYNC byte: no match on the cleared register, lock at cycle 8
        slen = 0;
        push_byte(8'h00);
        push_byte(8'h00);
        push_byte(8'h42);
        push_byte(8'h00);
        do_reset();
        stream_bits(slen);
        check("zero_sync active@1", 1,  8'(obs0_active[1]), 8'h00);
        check("zero_sync active@8", 8,  8'(obs0_active[8]), 8'h00);
        check("zero_sync active@9", 9,  8'(obs0_active[9]), 8'h01);
        check("zero_sync valid@25", 25, 8'(obs0_valid[25]), 8'h01);
        check("zero_sync data@25",  25, obs0_data[25],       8'h42);
        pulses = 0;
        for (int k = 0; k <= slen; k++) if (obs0_valid[k] === 1'b1) pulses++;
        check("zero_sync pulses", slen, 8'(pulses), 8'd1);

        // reset during bit 4 of a payload byte
        slen = 0;
        repeat (4) push_byte(SYNC_B);
        push_byte(8'h77);
        push_bit(1'b0); push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
        do_reset();
        stream_bits(slen);
        check("midreset pre_data",   slen, obs_data[slen],       8'h77);
        check("midreset pre_active", slen, 8'(obs_active[slen]), 8'h01);
        #2 RESET = 1'b1;
        #1;
        check("midreset async_data",   0, DATA_OUT,      8'h00);
        check("midreset async_valid",  0, 8'(VALID_OUT), 8'h00);
        check("midreset async_active", 0, 8'(ACTIVE),    8'h00);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        slen = 0;
        push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
        repeat (3) push_byte(SYNC_B);
        push_byte(8'h66);
        push_byte(SYNC_B);
        push_byte(SYNC_B);
        stream_bits(slen);
        check("midreset relock_pulses", slen, 8'(count_pulses(slen)), 8'd0);
        check("midreset relock_active", slen, 8'(obs_active[slen]),   8'h00);
        check("midreset relock_data",   slen, obs_data[slen],         8'h00);
        slen = 0;
        repeat (4) push_byte(SYNC_B);
        push_byte(8'h66);
        push_byte(SYNC_B);
        stream_bits(slen);
        check("midreset final_pulses", slen, 8'(count_pulses(slen)), 8'd1);
        check("midreset final_data",   slen, obs_data[slen],         8'h66);

        // long run of payload without SYNC bytes
        slen = 0;
        repeat (4) push_byte(SYNC_B);
        repeat (100) push_byte(8'h01);
        push_byte(SYNC_B);
        do_reset();
        stream_bits(slen);
        pulses = count_pulses(slen);
        drops = 0;
        for (int k = 33; k <= slen; k++) if (obs_active[k] !== 1'b1) drops++;
`ifdef LOSS_OF_SYNC_EN
        check("gap pulses",  slen, 8'(pulses), 8'd16);
        check("gap active",  slen, 8'(obs_active[slen]), 8'h00);
        check("gap drop_at", 33 + 16*8, 8'(obs_active[33 + 16*8]), 8'h00);
        check("gap hold_at", 32 + 16*8, 8'(obs_active[32 + 16*8]), 8'h01);
`else
        check("gap pulses",  slen, 8'(pulses), 8'd100);
        check("gap active",  slen, 8'(obs_active[slen]), 8'h01);
        check("gap drops",   slen, 8'(drops), 8'd0);
`endif
        compare_model("gap", slen);

        // random streams: SYNC runs, payload bursts and bit slips
        for (int r = 0; r < 8; r++) begin
            slen = 0;
            repeat ($urandom_range(4, 6)) push_byte(SYNC_B);
            for (int s = 0; s < 10; s++) begin
                case ($urandom_range(0, 3))
                    0: repeat ($urandom_range(1, 7)) push_bit(1'($urandom_range(0, 1)));
                    1: repeat ($urandom_range(2, 6)) push_byte(SYNC_B);
                    default: repeat ($urandom_range(1, 6)) push_byte(8'($urandom));
                endcase
            end
            push_byte(SYNC_B);
            push_byte(SYNC_B);
            n = slen;
            do_reset();
            stream_bits(n);
            compare_model($sformatf("rand%0d", r), n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sync_ctrl.md
SERIAL_SYNC_CTRL -- requirements
Module: serial_sync_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hBC: the comma/idle byte used for alignment and as filler.
REQ-002 Parameter SYNC_COUNT, default 4: consecutive aligned SYNC_BYTEs needed to go ACTIVE (legal range 1..15).
REQ-003 Parameter MAX_GAP, default 16: consecutive non-SYNC bytes that cause loss of sync (legal range 2..255; used only with LOSS_OF_SYNC_EN).
REQ-004 The block has one clock and an asynchronous, active-high reset.
REQ-005 CLK  input  1  clock; all state changes on the rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 DATA_IN  input  1  serial data, one bit per CLK, MSB of each byte first.
REQ-008 DATA_OUT  output  8  last delivered payload byte, registered.
REQ-009 VALID_OUT  output  1  one-cycle strobe; DATA_OUT is new and valid in this cycle.
REQ-010 ACTIVE  output  1  link aligned and delivering; registered, equals (state==ACTIVE).

Function
REQ-011 Internal shift register sr[7:0] SHALL load {sr[6:0],DATA_IN} every cycle in every non-reset state.
REQ-012 FSM states: HUNT, ALIGN, ACTIVE; the encoding is free.
REQ-013 HUNT: in any cycle where sr==SYNC_BYTE (bit-level sliding search), the FSM moves to ALIGN, sets sync_cnt to 1 and sets bit_cnt to 1.
REQ-014 bit_cnt is 3-bit, increments mod 8 every cycle outside HUNT; a byte-boundary cycle is a cycle with bit_cnt==0, and sr then holds one aligned byte.
REQ-015 ALIGN boundary with sr==SYNC_BYTE: sync_cnt increments; when the incremented value equals SYNC_COUNT, the FSM moves to ACTIVE.
REQ-016 ALIGN boundary with sr!=SYNC_BYTE: the FSM returns to HUNT and sync_cnt clears; no output changes.
REQ-017 If SYNC_COUNT==1, detection in HUNT moves the FSM directly to ACTIVE.
REQ-018 ACTIVE boundary with sr!=SYNC_BYTE: DATA_OUT<=sr and VALID_OUT<=1 at the closing edge (latency: valid one cycle after the boundary cycle).
REQ-019 ACTIVE boundary with sr==SYNC_BYTE: the byte is treated as filler; DATA_OUT holds and VALID_OUT stays 0.
REQ-020 VALID_OUT is 0 in every cycle not immediately following a delivering boundary; it never stays high for two consecutive cycles.
REQ-021 ACTIVE is never left except by reset, or by loss of sync when LOSS_OF_SYNC_EN is defined.
REQ-022 DATA_OUT holds its value across state changes, including the return to HUNT.

Reset
REQ-023 While RESET=1: state=HUNT, sr=8'h00, bit_cnt=0, sync_cnt=0, gap_cnt=0, DATA_OUT=8'h00, VALID_OUT=0, ACTIVE=0, all asynchronously.
REQ-024 Reset asserted mid-byte or in ACTIVE aborts immediately; after release, alignment restarts from HUNT and requires SYNC_COUNT fresh SYNC bytes.
REQ-025 If SYNC_BYTE==8'h00, the reset value of sr does not produce a detection in the first cycle after release; detection requires 8 shifted bits.

Configuration
REQ-026 Macro LOSS_OF_SYNC_EN defined: 8-bit gap_cnt counts consecutive non-SYNC boundaries in ACTIVE and clears on any SYNC boundary.
REQ-027 When gap_cnt reaches MAX_GAP, that byte is still delivered, then the FSM moves to HUNT, and ACTIVE drops in the next cycle.
REQ-028 Macro LOSS_OF_SYNC_EN undefined: gap_cnt logic is absent and ACTIVE stays high until reset.

Verification
REQ-029 Reset, then stream BC BC BC BC 11 22 -> ACTIVE rises 1 cycle after the 4th BC boundary; VALID_OUT pulses with DATA_OUT=11, then 22, 8 cycles apart.
REQ-030 Prefix 3 arbitrary bits, then BC x4, A5 -> lock despite misalignment; DATA_OUT=A5 with one VALID_OUT pulse.
REQ-031 Stream BC BC 3C BC BC BC BC 55 -> 3C forces return to HUNT; ACTIVE only after the later 4 BCs; 55 is delivered, 3C is never delivered.
REQ-032 In ACTIVE, send 77 BC 88 -> VALID_OUT pulses for 77 and 88 only; DATA_OUT holds 77 through the BC boundary.
REQ-033 With LOSS_OF_SYNC_EN and MAX_GAP=16, send 16 bytes of 0x01 in ACTIVE -> 16 VALID_OUT pulses, then ACTIVE=0; without the macro, ACTIVE stays 1 for 100 bytes.
REQ-034 Assert RESET for 2 cycles during bit 4 of a payload byte -> all outputs reset immediately; no VALID_OUT until re-lock on 4 BCs.
